// File: rtl/rv_stream_fifo.sv
// Valid/ready stream FIFO over a simple dual-port RAM. The RAM's registered read
// port doubles as the output stage, hiding its one-cycle read latency.

module rv_memory_double_port #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  p0_en,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_data_in,
  input  logic                  p1_en,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  output logic [DATA_WIDTH-1:0] p1_data_out
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] p1_data_q;

  // Contents and read register are deliberately not reset.
  always_ff @(posedge clk) begin
    if (p0_en && p0_we) begin
      mem_q[p0_addr] <= p0_data_in;
    end
    if (p1_en) begin
      p1_data_q <= mem_q[p1_addr];
    end
  end

  assign p1_data_out = p1_data_q;

endmodule

module rv_stream_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [ADDR_WIDTH:0]   FULL_CNT  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   ZERO_CNT  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ZERO_PTR  = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ONE_PTR   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   mem_count_q, mem_count_d;
  logic                  out_valid_q, out_valid_d;

  logic clr_s;
  logic push_s;
  logic issue_s;
  logic pop_s;
  logic p0_we_s;

  assign in_ready  = (mem_count_q != FULL_CNT);
  assign out_valid = out_valid_q;
  assign count     = mem_count_q + {ZERO_PTR, out_valid_q};
  assign p0_we_s   = 1'b1;

  // Handshake decode and next-state; a clear (flush or reset) masks every RAM access.
  always_comb begin
    clr_s   = flush || !rst;
    push_s  = in_valid && in_ready && !clr_s;
    issue_s = (mem_count_q != ZERO_CNT) && (!out_valid_q || out_ready) && !clr_s;
    pop_s   = out_valid_q && out_ready;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_count_d = mem_count_q;
    out_valid_d = out_valid_q;

    if (clr_s) begin
      wr_ptr_d    = ZERO_PTR;
      rd_ptr_d    = ZERO_PTR;
      mem_count_d = ZERO_CNT;
      out_valid_d = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + ONE_PTR;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (issue_s) begin
        rd_ptr_d = rd_ptr_q + ONE_PTR;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      mem_count_d = mem_count_q + {ZERO_PTR, push_s} - {ZERO_PTR, issue_s};
      if (issue_s) begin
        out_valid_d = 1'b1;
      end else if (pop_s) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= ZERO_PTR;
      rd_ptr_q    <= ZERO_PTR;
      mem_count_q <= ZERO_CNT;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      out_valid_q <= out_valid_d;
    end
  end

  rv_memory_double_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk         (clk),
    .p0_en       (push_s),
    .p0_we       (p0_we_s),
    .p0_addr     (wr_ptr_q),
    .p0_data_in  (in_data),
    .p1_en       (issue_s),
    .p1_addr     (rd_ptr_q),
    .p1_data_out (out_data)
  );

endmodule

// File: tb/tb_rv_stream_fifo.sv
// Directed, scoreboard-based bench for rv_stream_fifo (DATA_WIDTH=8, ADDR_WIDTH=2).

module tb_rv_stream_fifo;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW:0]   count;

  int checks   = 0;
  int failures = 0;
  int pops     = 0;
  logic [DW-1:0] sb_q[$];

  rv_stream_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observe handshakes just before the edge, update the scoreboard, then advance one cycle.
  task automatic step();
    logic [DW-1:0] exp_d;
    if (!rst || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        pops++;
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          exp_d = sb_q.pop_front();
          chk("sb_data", 32'(out_data), 32'(exp_d));
        end
      end
      if (in_valid && in_ready) sb_q.push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    out_ready = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (!out_valid && count == 0) break;
      step();
    end
    chk("drain_done_count", 32'(count), 32'd0);
    chk("drain_sb_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] held;
    logic          hold_chk;
    logic          bp_pat [6];
    bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (3) step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_p0_en", 32'(u_dut.push_s), 32'd0);
    chk("rst_p1_en", 32'(u_dut.issue_s), 32'd0);
    rst = 1'b1;
    step();
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_count", 32'(count), 32'd0);
    chk("idle_p1_en", 32'(u_dut.issue_s), 32'd0);

    // Latency
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lat_count_k1", 32'(count), 32'd1);
    chk("lat_ovalid_k1", 32'(out_valid), 32'd0);
    step();
    chk("lat_ovalid_k2", 32'(out_valid), 32'd1);
    chk("lat_data_k2", 32'(out_data), 32'hA5);
    step();
    chk("lat_ovalid_k3", 32'(out_valid), 32'd0);
    chk("lat_count_k3", 32'(count), 32'd0);

    // Fill to full with output stalled
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      if (i == 6) chk("full_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("full_count", 32'(count), 32'd5);
    chk("full_sb_size", 32'(sb_q.size()), 32'd5);
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("drain_count", 32'(count), 32'(5 - i));
      if (i == 1) chk("drain_in_ready", 32'(in_ready), 32'd1);
    end
    chk("drain_sb_empty_full", 32'(sb_q.size()), 32'd0);

    // Streaming through pointer wrap
    pops = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      step();
      if (i >= 1) begin
        chk("stream_count", 32'(count), 32'd2);
        chk("stream_ovalid", 32'(out_valid), 32'd1);
      end
    end
    in_valid = 1'b0;
    drain(10);
    chk("stream_pops", 32'(pops), 32'd20);

    // Backpressure stability
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h50 + 8'(i));
      step();
    end
    in_valid = 1'b0;
    chk("bp_count", 32'(count), 32'd3);
    for (int i = 0; i < 6; i++) begin
      out_ready = bp_pat[i];
      hold_chk = out_valid && !out_ready;
      held = out_data;
      step();
      if (hold_chk) chk("bp_hold", 32'(out_data), 32'(held));
    end
    drain(10);

    // Flush colliding with push and pop
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h20 + 8'(i));
      step();
    end
    chk("fl_pre_count", 32'(count), 32'd4);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_ovalid", 32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    chk("fl_next_valid", 32'(out_valid), 32'd1);
    chk("fl_next_data", 32'(out_data), 32'h3C);
    drain(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_stream_fifo.md
# rv_stream_fifo

Valid/ready stream FIFO built around a `rv_memory_double_port` instance: port 0 is the write port, port 1 the registered read port. It sits directly upstream of the block RAM and drives its ports. Its main job is to hide the RAM's one-cycle read latency behind a standard valid/ready stream. The RAM's port-1 output register serves as the FIFO's output stage, so no extra data register is needed.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each entry
- ADDR_WIDTH, 5, RAM address width; DEPTH = 2**ADDR_WIDTH RAM entries; total capacity DEPTH+1 (RAM plus output register); ADDR_WIDTH >= 1

Ports:
- clk  input  1  clock; single clock domain
- rst  input  1  reset; synchronous, active-low (state clears on a rising clk edge when rst == 0)
- flush  input  1  synchronous clear of all contents
- in_valid  input  1  producer has data
- in_ready  output  1  FIFO accepts data
- in_data  input  DATA_WIDTH  write data
- out_valid  output  1  out_data holds the head entry
- out_ready  input  1  consumer takes the head entry
- out_data  output  DATA_WIDTH  head entry (RAM port-1 data_out)
- count  output  ADDR_WIDTH+1  occupancy: mem_count + out_valid, range 0..DEPTH+1

## Operation
- State: wr_ptr, rd_ptr (ADDR_WIDTH bits each, wrap modulo DEPTH), mem_count (ADDR_WIDTH+1 bits), out_valid flag.
- push = in_valid && in_ready. On push, RAM port 0 is enabled with write_enable=1, addr=wr_ptr, data=in_data; then wr_ptr++.
- issue = (mem_count != 0) && (!out_valid || out_ready). On issue, RAM port 1 is enabled (read) at rd_ptr; then rd_ptr++.
- pop = out_valid && out_ready.
- mem_count_next = mem_count + push - issue. Both may occur in the same cycle (net 0).
- out_valid_next = issue ? 1 : (pop ? 0 : out_valid).
- While out_valid=1 and out_ready=0, port 1 stays disabled, so out_data holds stable.
- in_ready = (mem_count != DEPTH). It is a pure function of registered state, with no combinational path from out_ready. At mem_count==DEPTH, a simultaneous pop does not raise in_ready in that cycle.
- No read/write address collision can occur: issue requires mem_count>0, so rd_ptr != wr_ptr whenever both ports are active.
- count = mem_count + out_valid, computed combinationally from registers.
- Flush: pointers, mem_count and out_valid clear next edge. Flush has priority over push/pop/issue in the same cycle; those are ignored and port enables are forced low. in_ready and out_valid take no combinational dependence on flush.
- Reset (rst==0): same effect as flush and overrides it. RAM contents are not cleared.
- Signed/unsigned: all counters unsigned; pointer wrap is natural modulo 2**ADDR_WIDTH.

## Timing
- Reset values: in_ready=1, out_valid=0, count=0, out_data not reset (undefined until first out_valid; benches mask it).
- First-word latency: a push in cycle k into an empty FIFO raises out_valid in cycle k+2; count=1 from cycle k+1.
- Throughput: 1 entry/cycle sustained when in_valid=out_ready=1 continuously.
- Full: count==DEPTH+1, in_ready=0.
- in_ready rises the cycle after the first issue that drops mem_count below DEPTH.
- out_valid falls the cycle after a pop when mem_count was 0.
- Mid-operation reset or flush: next cycle is indistinguishable from post-reset. In-flight reads are discarded, since out_valid=0 regardless of port-1 data.

## Test plan
- Reset/idle (DATA_WIDTH=8, ADDR_WIDTH=2): hold rst=0 3 cycles, release → in_ready=1, out_valid=0, count=0, RAM port enables low.
- Latency: push 0xA5 in cycle 10, out_ready=1 → count=1 at cycle 11; out_valid=1, out_data=0xA5 at cycle 12; out_valid=0 at cycle 13.
- Fill/full: out_ready=0, push 0x01..0x06 on consecutive cycles → first 5 accepted, count=5, in_ready=0 and 0x06 is not accepted; then out_ready=1 → drains 0x01..0x05 in order, one per cycle, and in_ready returns 1 the cycle after the first issue.
- Streaming with wrap: in_valid=out_ready=1 for 20 cycles with data 0..19 → outputs 0..19 in order with no bubbles after the initial 2-cycle latency; count stays at 2 once steady.
- Backpressure stability: 3 entries queued, toggle out_ready 1,0,0,1,0,1 → out_data constant while out_valid && !out_ready; order preserved; no duplicates or losses.
- Flush collision: with count=4, assert flush with in_valid=1 and out_ready=1 in the same cycle → next cycle count=0, out_valid=0, in_ready=1; a subsequent push of 0x3C emerges as the next output.
